hwpe_sel_ctrl: RTL

- Control stage directly upstream of the cluster HWPE subsystem.
- Owns the HWPE enable and HWPE select signals that the subsystem consumes; software programs them through a small register port.
- Sits in series on the HWPE config bus. Before a select or enable change takes effect, it drains outstanding config transactions and waits for the active HWPE to go idle, so the subsystem's static muxes never switch mid-transaction.

---
 rtl/hwpe_sel_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/hwpe_sel_ctrl.sv
// HWPE enable/select controller: drains the config bus and waits for idle before switching.
// Optional DRAIN watchdog enabled by defining HWPE_SEL_CTRL_TIMEOUT_EN.
module hwpe_sel_ctrl #(
  parameter int unsigned MAX_NUM_HWPES   = 4,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned SWITCH_SETTLE   = 2,
  parameter int unsigned DRAIN_TIMEOUT   = 1024,
  localparam int unsigned SW = (MAX_NUM_HWPES > 1) ? $clog2(MAX_NUM_HWPES) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                reg_req_i,
  input  logic [31:0]         reg_add_i,
  input  logic                reg_wen_i,
  input  logic [31:0]         reg_wdata_i,
  input  logic [3:0]          reg_be_i,
  input  logic [ID_WIDTH-1:0] reg_id_i,
  output logic                reg_gnt_o,
  output logic                reg_r_valid_o,
  output logic [31:0]         reg_r_rdata_o,
  output logic [ID_WIDTH-1:0] reg_r_id_o,
  input  logic                cfg_req_i,
  output logic                cfg_gnt_o,
  output logic                cfg_req_o,
  input  logic                cfg_gnt_i,
  input  logic                cfg_r_valid_i,
  input  logic                hwpe_busy_i,
  output logic                hwpe_en_o,
  output logic [SW-1:0]       hwpe_sel_o,
  output logic                switching_o
);

  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SCW = (SWITCH_SETTLE > 1) ? $clog2(SWITCH_SETTLE) : 1;

  typedef enum logic [1:0] {StStable, StDrain, StSettle} state_e;

  state_e              state_q, state_d;
  logic                en_q, en_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                pend_en_q, pend_en_d;
  logic [SW-1:0]       pend_sel_q, pend_sel_d;
  logic [OW-1:0]       out_q, out_d;
  logic [SCW-1:0]      settle_q, settle_d;
  logic                r_valid_q;
  logic [31:0]         r_rdata_q, r_rdata_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;

  logic          is_ctrl, is_status, ctrl_wr, reg_gnt, status_rd;
  logic          wr_en;
  logic [SW-1:0] wr_sel;
  logic          cfg_allow, drain_done, out_clear, out_inc;
  logic          timeout_hit, timeout_sticky;
  logic [31:0]   rd_data;
  logic          unused_in;

  assign unused_in = ^{reg_add_i, reg_wdata_i, reg_be_i};

  assign is_ctrl   = (reg_add_i[3:2] == 2'd0);
  assign is_status = (reg_add_i[3:2] == 2'd1);
  assign ctrl_wr   = reg_req_i && !reg_wen_i && is_ctrl;
  // CTRL writes wait for STABLE so a switch is never retargeted mid-flight
  assign reg_gnt   = reg_req_i && !(ctrl_wr && (state_q != StStable));
  assign status_rd = reg_gnt && reg_wen_i && is_status;

  assign wr_en  = reg_be_i[0] ? reg_wdata_i[0] : en_q;
  assign wr_sel = reg_be_i[1] ? reg_wdata_i[8 +: SW] : sel_q;

  assign cfg_allow  = (state_q == StStable) && (out_q < OW'(MAX_OUTSTANDING));
  assign cfg_req_o  = cfg_req_i && cfg_allow;
  assign cfg_gnt_o  = cfg_gnt_i && cfg_allow;
  assign out_inc    = cfg_req_o && cfg_gnt_i;
  assign drain_done = (out_q == '0) && (!hwpe_busy_i || !en_q);

`ifdef HWPE_SEL_CTRL_TIMEOUT_EN
  localparam int unsigned TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  logic [TW-1:0] drain_cnt_q, drain_cnt_d;
  logic          sticky_q, sticky_d;

  assign timeout_hit    = (state_q == StDrain) && !drain_done &&
                          (drain_cnt_q == TW'(DRAIN_TIMEOUT - 1));
  assign timeout_sticky = sticky_q;

  always_comb begin
    drain_cnt_d = (state_q == StDrain) ? drain_cnt_q + 1'b1 : '0;
    sticky_d    = sticky_q;
    if (status_rd) sticky_d = 1'b0;
    if (timeout_hit) sticky_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drain_cnt_q <= '0;
      sticky_q    <= 1'b0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
      sticky_q    <= sticky_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^DRAIN_TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign timeout_sticky = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    sel_d      = sel_q;
    pend_en_d  = pend_en_q;
    pend_sel_d = pend_sel_q;
    settle_d   = settle_q;
    out_clear  = 1'b0;
    unique case (state_q)
      StStable: begin
        if (reg_gnt && ctrl_wr && ({wr_en, wr_sel} != {en_q, sel_q})) begin
          pend_en_d  = wr_en;
          pend_sel_d = wr_sel;
          state_d    = StDrain;
        end
      end
      StDrain: begin
        if (drain_done || timeout_hit) begin
          state_d   = StSettle;
          en_d      = 1'b0;
          sel_d     = pend_sel_q;
          settle_d  = '0;
          out_clear = timeout_hit;
        end
      end
      StSettle: begin
        if (settle_q == SCW'(SWITCH_SETTLE - 1)) begin
          state_d = StStable;
          en_d    = pend_en_q;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      default: state_d = StStable;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (out_inc && !cfg_r_valid_i && (out_q < OW'(MAX_OUTSTANDING))) out_d = out_q + 1'b1;
    else if (cfg_r_valid_i && !out_inc && (out_q != '0)) out_d = out_q - 1'b1;
    if (out_clear) out_d = '0;
  end

  always_comb begin
    rd_data = '0;
    if (is_ctrl) begin
      rd_data[0]       = en_q;
      rd_data[8 +: SW] = sel_q;
    end else if (is_status) begin
      rd_data[0]       = (state_q != StStable);
      rd_data[1]       = hwpe_busy_i;
      rd_data[2]       = timeout_sticky;
      rd_data[8 +: SW] = sel_q;
    end
    r_rdata_d = (reg_gnt && reg_wen_i) ? rd_data : '0;
    r_id_d    = reg_gnt ? reg_id_i : r_id_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StStable;
      en_q       <= 1'b0;
      sel_q      <= '0;
      pend_en_q  <= 1'b0;
      pend_sel_q <= '0;
      out_q      <= '0;
      settle_q   <= '0;
      r_valid_q  <= 1'b0;
      r_rdata_q  <= '0;
      r_id_q     <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      sel_q      <= sel_d;
      pend_en_q  <= pend_en_d;
      pend_sel_q <= pend_sel_d;
      out_q      <= out_d;
      settle_q   <= settle_d;
      r_valid_q  <= reg_gnt;
      r_rdata_q  <= r_rdata_d;
      r_id_q     <= r_id_d;
    end
  end

  assign reg_gnt_o     = reg_gnt;
  assign reg_r_valid_o = r_valid_q;
  assign reg_r_rdata_o = r_rdata_q;
  assign reg_r_id_o    = r_id_q;
  assign hwpe_en_o     = en_q;
  assign hwpe_sel_o    = sel_q;
  assign switching_o   = (state_q != StStable);

endmodule
